// File: rtl/enemy_pkg.sv
// Shared field layout, FSM states and direction codes for the enemy slots.
package enemy_pkg;

    localparam int unsigned STATE_W = 32;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned SPD_W   = 5;
    localparam int unsigned COL_W   = 2;
    localparam int unsigned X_LSB   = 22;
    localparam int unsigned Y_LSB   = 12;
    localparam int unsigned SPD_LSB = 7;
    localparam int unsigned DIR_BIT = 1;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        STEP
    } schedState_t;

endpackage

// File: rtl/enemy_predict.sv
// Unpacks one enemy state word and predicts its next x position (wraps mod 1024).
module enemy_predict
    import enemy_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    output logic [POS_W-1:0]   x,
    output logic [POS_W-1:0]   y,
    output logic [SPD_W-1:0]   speed,
    output logic               dir,
    output logic [POS_W-1:0]   nextX
);

    logic unusedBits;

    assign x     = state[X_LSB +: POS_W];
    assign y     = state[Y_LSB +: POS_W];
    assign speed = state[SPD_LSB +: SPD_W];
    assign dir   = state[DIR_BIT];
    assign nextX = (dir == RIGHT) ? x + POS_W'(speed) : x - POS_W'(speed);

    // Reserved bits of the state word carry nothing for prediction.
    assign unusedBits = ^{state[SPD_LSB-1:DIR_BIT+1], state[0]};

endmodule

// File: rtl/enemy_scheduler.sv
// Walks enabled enemy slots through one shared collision-query port per tick,
// then strobes enemy_step with the collected collision vectors.
module enemy_scheduler
    import enemy_pkg::*;
#(
    parameter  int unsigned N_ENEMIES = 4,
    parameter  int unsigned TIMEOUT   = 15,
    localparam int unsigned IDX_W     = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1
) (
    input  logic                         sim_clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic [N_ENEMIES-1:0]         enable,
    input  logic [STATE_W*N_ENEMIES-1:0] enemy_state,
    output logic                         q_valid,
    input  logic                         q_ready,
    output logic [POS_W-1:0]             q_x,
    output logic [POS_W-1:0]             q_y,
    output logic                         q_dir,
    output logic [IDX_W-1:0]             q_slot,
    input  logic                         r_valid,
    input  logic [COL_W-1:0]             r_col,
    output logic [COL_W*N_ENEMIES-1:0]   enemy_col,
    output logic [N_ENEMIES-1:0]         enemy_step,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun,
    output logic                         timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    schedState_t                 state;
    logic [IDX_W-1:0]            idx;
    logic [N_ENEMIES-1:0]        enQ;
    logic [COL_W*N_ENEMIES-1:0]  colQ;
    logic [COL_W*N_ENEMIES-1:0]  colNext;
    logic [CNT_W-1:0]            waitCnt;
    logic [STATE_W-1:0]          slotState;
    logic [POS_W-1:0]            predX;
    logic [POS_W-1:0]            predY;
    logic                        predDir;
    logic [POS_W-1:0]            unusedX;
    logic [SPD_W-1:0]            unusedSpeed;
    logic                        slotActive;
    logic                        lastSlot;
    logic                        capture;
    logic                        advance;
    logic [COL_W-1:0]            capVal;

    assign slotState = enemy_state[STATE_W*int'(idx) +: STATE_W];

    enemy_predict uPredict (
        .state (slotState),
        .x     (unusedX),
        .y     (predY),
        .speed (unusedSpeed),
        .dir   (predDir),
        .nextX (predX)
    );

    // Query fields are live only while an enabled slot is being issued.
    assign slotActive = (state == ISSUE) && enQ[idx];
    assign q_valid    = slotActive;
    assign q_x        = slotActive ? predX : '0;
    assign q_y        = slotActive ? predY : '0;
    assign q_dir      = slotActive & predDir;
    assign q_slot     = slotActive ? idx : '0;
    assign lastSlot   = (idx == IDX_W'(N_ENEMIES - 1));

    // A missing response counts as blocked on both sides so the enemy reverses.
    always_comb begin
        capture = (state == WAIT) && (r_valid || (waitCnt == CNT_W'(TIMEOUT - 1)));
        capVal  = r_valid ? r_col : 2'b11;
        advance = ((state == ISSUE) && !enQ[idx]) || capture;
        colNext = colQ;
        if (capture) begin
            colNext[COL_W*int'(idx) +: COL_W] = capVal;
        end
    end

    always_ff @(posedge sim_clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            enQ         <= '0;
            colQ        <= '0;
            waitCnt     <= '0;
            enemy_col   <= '0;
            enemy_step  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            enemy_step <= '0;
            enemy_col  <= '0;
            done       <= 1'b0;
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        enQ   <= enable;
                        idx   <= '0;
                        colQ  <= '0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (slotActive && q_ready) begin
                        waitCnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt + CNT_W'(1);
                    if (capture) begin
                        colQ <= colNext;
                        if (!r_valid) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (advance) begin
                if (lastSlot) begin
                    enemy_step <= enQ;
                    enemy_col  <= colNext;
                    done       <= 1'b1;
                    state      <= STEP;
                end else begin
                    idx   <= idx + IDX_W'(1);
                    state <= ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_enemy_scheduler.sv
// Directed bench for enemy_scheduler with a small scripted collision responder.
module tb_enemy_scheduler;

    logic         sim_clk;
    logic         reset;
    logic         tick;
    logic [3:0]   enable;
    logic [127:0] enemy_state;
    logic         q_valid;
    logic         q_ready;
    logic [9:0]   q_x;
    logic [9:0]   q_y;
    logic         q_dir;
    logic [1:0]   q_slot;
    logic         r_valid;
    logic [1:0]   r_col;
    logic [7:0]   enemy_col;
    logic [3:0]   enemy_step;
    logic         busy;
    logic         done;
    logic         overrun;
    logic         timeout_err;

    int vectors;
    int miscompares;
    int cyc;
    int stallLeft;
    int noRespSlot;

    logic [31:0] stateTab [4];
    logic [1:0]  colTable [4];
    logic [9:0]  firstQx  [4];
    logic [9:0]  firstQy  [4];
    logic        firstQd  [4];
    logic        seen     [4];

    enemy_scheduler dut (
        .sim_clk     (sim_clk),
        .reset       (reset),
        .tick        (tick),
        .enable      (enable),
        .enemy_state (enemy_state),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .q_x         (q_x),
        .q_y         (q_y),
        .q_dir       (q_dir),
        .q_slot      (q_slot),
        .r_valid     (r_valid),
        .r_col       (r_col),
        .enemy_col   (enemy_col),
        .enemy_step  (enemy_step),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial sim_clk = 1'b0;
    always #5 sim_clk = ~sim_clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] packState(input int x, input int y, input int spd, input logic dir);
        return {10'(x), 10'(y), 5'(spd), 5'b0, dir, 1'b0};
    endfunction

    function automatic logic [9:0] tbPredX(input logic [31:0] s);
        logic [9:0] x;
        logic [9:0] sp;
        x  = s[31:22];
        sp = {5'b0, s[11:7]};
        return s[1] ? x + sp : x - sp;
    endfunction

    task automatic doReset();
        reset      = 1'b1;
        tick       = 1'b0;
        r_valid    = 1'b0;
        r_col      = 2'b00;
        q_ready    = 1'b1;
        stallLeft  = 0;
        noRespSlot = -1;
        enemy_state = {stateTab[3], stateTab[2], stateTab[1], stateTab[0]};
        repeat (2) @(posedge sim_clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock: responder answers in the cycle after acceptance, optional ready stall.
    task automatic advanceCycle();
        logic       acc;
        logic [1:0] sl;
        acc = q_valid && q_ready;
        sl  = q_slot;
        @(posedge sim_clk);
        #1;
        cyc++;
        tick    = 1'b0;
        reset   = 1'b0;
        r_valid = acc && (int'(sl) != noRespSlot);
        r_col   = colTable[sl];
        if (q_valid && stallLeft > 0) begin
            q_ready = 1'b0;
            stallLeft--;
        end else begin
            q_ready = 1'b1;
        end
        if (q_valid && !seen[q_slot]) begin
            seen[q_slot]    = 1'b1;
            firstQx[q_slot] = q_x;
            firstQy[q_slot] = q_y;
            firstQd[q_slot] = q_dir;
        end
    endtask

    task automatic checkZeroOutputs(input string pfx);
        checkVal({pfx, "_q_valid"}, 32'(q_valid), 0);
        checkVal({pfx, "_q_x"}, 32'(q_x), 0);
        checkVal({pfx, "_q_slot"}, 32'(q_slot), 0);
        checkVal({pfx, "_busy"}, 32'(busy), 0);
        checkVal({pfx, "_done"}, 32'(done), 0);
        checkVal({pfx, "_enemy_step"}, 32'(enemy_step), 0);
        checkVal({pfx, "_enemy_col"}, 32'(enemy_col), 0);
        checkVal({pfx, "_overrun"}, 32'(overrun), 0);
        checkVal({pfx, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    task automatic runWalk(input string name, input logic [3:0] en, input int extraTickAt,
                           input int resetAt, input int expStepCyc, input logic [3:0] expStep,
                           input logic [7:0] expCol, input logic expTimeout);
        int         firstDone;
        int         doneCnt;
        logic [3:0] stepVec;
        logic [7:0] colVec;
        logic       toErr;
        firstDone = -1;
        doneCnt   = 0;
        stepVec   = '0;
        colVec    = '0;
        toErr     = 1'b0;
        for (int s = 0; s < 4; s++) seen[s] = 1'b0;
        enable = en;
        tick   = 1'b1;
        cyc    = 0;
        for (int k = 0; k < 40; k++) begin
            advanceCycle();
            if (cyc == 1 && resetAt < 0) checkVal({name, "_busy_t1"}, 32'(busy), 1);
            if (q_valid && !q_ready) begin
                checkVal({name, "_stall_q_x"}, 32'(q_x), 32'(tbPredX(stateTab[0])));
                checkVal({name, "_stall_q_slot"}, 32'(q_slot), 0);
            end
            if (done) begin
                doneCnt++;
                if (firstDone < 0) begin
                    firstDone = cyc;
                    stepVec   = enemy_step;
                    colVec    = enemy_col;
                    toErr     = timeout_err;
                end
            end
            if (firstDone >= 0 && cyc == firstDone + 1) begin
                checkVal({name, "_col_after_step"}, 32'(enemy_col), 0);
                checkVal({name, "_busy_after_step"}, 32'(busy), 0);
            end
            if (extraTickAt >= 0 && cyc == extraTickAt + 1)
                checkVal({name, "_overrun"}, 32'(overrun), 1);
            if (resetAt >= 0 && cyc == resetAt + 1)
                checkZeroOutputs({name, "_post_reset"});
            if (cyc == extraTickAt) tick = 1'b1;
            if (cyc == resetAt) reset = 1'b1;
        end
        if (resetAt < 0) begin
            checkVal({name, "_step_cycle"}, 32'(firstDone), 32'(expStepCyc));
            checkVal({name, "_done_count"}, 32'(doneCnt), 1);
            checkVal({name, "_enemy_step"}, 32'(stepVec), 32'(expStep));
            checkVal({name, "_enemy_col"}, 32'(colVec), 32'(expCol));
            checkVal({name, "_timeout_err"}, 32'(toErr), 32'(expTimeout));
        end else begin
            checkVal({name, "_done_count"}, 32'(doneCnt), 0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        stateTab[0] = packState(200, 150, 3, 1'b1);
        stateTab[1] = packState(100, 50, 7, 1'b0);
        stateTab[2] = packState(1022, 10, 5, 1'b1);
        stateTab[3] = packState(2, 20, 5, 1'b0);
        for (int s = 0; s < 4; s++) colTable[s] = 2'b00;
        enable = '0;

        doReset();
        checkZeroOutputs("reset");

        // All four slots, ideal responder; includes both wrap cases.
        colTable[1] = 2'b01;
        doReset();
        runWalk("ideal", 4'b1111, -1, -1, 9, 4'b1111, 8'b0000_0100, 1'b0);
        checkVal("ideal_q_x0", 32'(firstQx[0]), 203);
        checkVal("ideal_q_y0", 32'(firstQy[0]), 150);
        checkVal("ideal_q_dir0", 32'(firstQd[0]), 1);
        checkVal("ideal_q_x1", 32'(firstQx[1]), 93);
        checkVal("ideal_q_x_wrap_right", 32'(firstQx[2]), 3);
        checkVal("ideal_q_x_wrap_left", 32'(firstQx[3]), 1021);
        checkVal("ideal_q_dir3", 32'(firstQd[3]), 0);

        // Sparse enable; disabled slots must not pick up responder values.
        colTable[0] = 2'b01;
        colTable[1] = 2'b11;
        colTable[2] = 2'b10;
        colTable[3] = 2'b11;
        doReset();
        runWalk("sparse", 4'b0101, -1, -1, 7, 4'b0101, 8'b0010_0001, 1'b0);
        checkVal("sparse_seen1", 32'(seen[1]), 0);

        // Ready held low five cycles on slot 0.
        for (int s = 0; s < 4; s++) colTable[s] = 2'b00;
        doReset();
        stallLeft = 5;
        runWalk("stall", 4'b1111, -1, -1, 14, 4'b1111, 8'h00, 1'b0);

        // Slot 1 never answers.
        colTable[3] = 2'b01;
        doReset();
        noRespSlot = 1;
        runWalk("timeout", 4'b1111, -1, -1, 23, 4'b1111, 8'b0100_1100, 1'b1);

        // Tick while busy: flagged, walk not restarted.
        colTable[3] = 2'b00;
        doReset();
        runWalk("overrun", 4'b1111, 4, -1, 9, 4'b1111, 8'h00, 1'b0);

        // Reset mid-walk after an overrun.
        doReset();
        runWalk("abort", 4'b1111, 4, 5, 0, 4'b0000, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
